// File: rtl/mem_access_unit.sv
// Load/store unit between the CPU and a word-wide data memory. Sub-word and
// line-spanning stores use read-modify-write; unaligned loads may read two words.
module mem_access_unit #(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] d_mem_addr,
  output logic [31:0] d_mem_wdata,
  output logic [3:0]  d_mem_wen,
  input  logic [31:0] d_mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD0, RD1, WR0, WR1, RESP} state_t;

  state_t      state;
  logic        we_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] cap0;
  logic [31:0] cap1;

  logic [1:0]  off;
  logic [2:0]  nbytes;
  logic        span;
  logic [31:0] word0;
  logic [31:0] word1;
  logic        err;
  logic [63:0] lane_mask;
  logic [63:0] merged;
  logic [63:0] shifted;
  logic [31:0] load_val;
  logic        direct_wr;

  assign req_ready = (state == IDLE);
  assign direct_wr = req_we && req_size[1] && (req_addr[1:0] == 2'b00);

  always_comb begin
    off    = addr_q[1:0];
    nbytes = (size_q == 2'b00) ? 3'd1 : (size_q == 2'b01) ? 3'd2 : 3'd4;
    span   = ({1'b0, off} + nbytes) > 3'd4;
    word0  = {addr_q[31:2], 2'b00};
    word1  = word0 + 32'd4;
    err    = ({2'b00, word0[31:2]} >= MEM_WORDS) ||
             (span && ({2'b00, word1[31:2]} >= MEM_WORDS));
  end

  // Both captured words form one little-endian 8-byte window; the addressed
  // bytes are spliced in (stores) or shifted down (loads) at the byte offset.
  always_comb begin
    lane_mask = (nbytes == 3'd1) ? 64'h0000_0000_0000_00FF :
                (nbytes == 3'd2) ? 64'h0000_0000_0000_FFFF :
                                   64'h0000_0000_FFFF_FFFF;
    lane_mask = lane_mask << {off, 3'b000};
    merged    = ({cap1, cap0} & ~lane_mask) |
                (({32'h0, wdata_q} << {off, 3'b000}) & lane_mask);
    shifted   = {cap1, cap0} >> {off, 3'b000};
    case (size_q)
      2'b00:   load_val = uns_q ? {24'h0, shifted[7:0]}
                                : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = uns_q ? {16'h0, shifted[15:0]}
                                : {{16{shifted[15]}}, shifted[15:0]};
      default: load_val = shifted[31:0];
    endcase
  end

  always_comb begin
    d_mem_addr  = '0;
    d_mem_wdata = '0;
    d_mem_wen   = '0;
    case (state)
      RD0: d_mem_addr = word0;
      RD1: d_mem_addr = word1;
      WR0: begin
        d_mem_addr  = word0;
        d_mem_wdata = merged[31:0];
        d_mem_wen   = err ? 4'b0000 : 4'b1111;
      end
      WR1: begin
        d_mem_addr  = word1;
        d_mem_wdata = merged[63:32];
        d_mem_wen   = err ? 4'b0000 : 4'b1111;
      end
      default: ;
    endcase
    if (!rst_n) d_mem_wen = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cap0       <= '0;
      cap1       <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          we_q    <= req_we;
          uns_q   <= req_unsigned;
          size_q  <= req_size;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          state   <= direct_wr ? WR0 : RD0;
        end
        RD0: begin
          cap0  <= d_mem_rdata;
          state <= span ? RD1 : (we_q ? WR0 : RESP);
        end
        RD1: begin
          cap1  <= d_mem_rdata;
          state <= we_q ? WR0 : RESP;
        end
        WR0: state <= span ? WR1 : RESP;
        WR1: state <= RESP;
        RESP: begin
          resp_valid <= 1'b1;
          resp_rdata <= (we_q || err) ? 32'h0 : load_val;
          resp_err   <= err;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboarded bench for mem_access_unit with a 1024-word behavioural memory.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] d_mem_addr;
  logic [31:0] d_mem_wdata;
  logic [3:0]  d_mem_wen;
  logic [31:0] d_mem_rdata;

  mem_access_unit #(.MEM_WORDS(1024)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .d_mem_addr(d_mem_addr),
    .d_mem_wdata(d_mem_wdata), .d_mem_wen(d_mem_wen), .d_mem_rdata(d_mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] rdata; logic err; int lat; int acc; } exp_t;
  typedef struct { logic [31:0] rdata; logic err; int cyc; } got_t;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  exp_t        exp_q[$];
  got_t        got_q[$];
  logic [31:0] addr_log[$];
  int          cyc = 0;
  int          wen_cycles = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  assign d_mem_rdata = (d_mem_addr[31:2] < 30'd1024) ? mem[d_mem_addr[11:2]] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (d_mem_wen != 4'b0000 && d_mem_addr[31:2] < 30'd1024)
      for (int k = 0; k < 4; k++)
        if (d_mem_wen[k]) mem[d_mem_addr[11:2]][8*k +: 8] = d_mem_wdata[8*k +: 8];
  end

  always @(negedge clk) begin
    if (resp_valid) got_q.push_back('{rdata: resp_rdata, err: resp_err, cyc: cyc});
    if (d_mem_wen != 4'b0000) wen_cycles++;
    if (d_mem_addr != 32'h0) addr_log.push_back(d_mem_addr);
  end

  // Byte-at-a-time reference: loads assemble, stores patch ref_mem.
  function automatic void model(input bit we, input logic [1:0] size, input bit uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rd, output bit er, output int lat);
    int unsigned n;
    logic [31:0] last, a, v;
    logic [7:0]  b;
    bit          sp;
    n    = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    last = addr + n - 1;
    sp   = (addr[31:2] != last[31:2]);
    er   = (addr[31:2] >= 30'd1024) || (sp && last[31:2] >= 30'd1024);
    v    = '0;
    if (!er)
      for (int unsigned i = 0; i < n; i++) begin
        a = addr + i;
        if (we) begin
          b = 8'((wdata >> (8 * i)) & 32'hFF);
          ref_mem[a[11:2]] = (ref_mem[a[11:2]] & ~(32'hFF << {a[1:0], 3'b000})) |
                             ({24'h0, b} << {a[1:0], 3'b000});
        end else begin
          b = 8'((ref_mem[a[11:2]] >> {a[1:0], 3'b000}) & 32'hFF);
          v = v | ({24'h0, b} << (8 * i));
        end
      end
    if (!we && !uns && n == 1) v = {{24{v[7]}}, v[7:0]};
    if (!we && !uns && n == 2) v = {{16{v[15]}}, v[15:0]};
    rd  = (we || er) ? 32'h0 : v;
    lat = we ? ((n == 4 && addr[1:0] == 2'b00) ? 2 : (sp ? 5 : 3)) : (sp ? 3 : 2);
  endfunction

  task automatic preload();
    for (int i = 0; i < 1024; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    mem[64] = 32'h8899_AABB; ref_mem[64] = 32'h8899_AABB;
    mem[65] = 32'h1122_3344; ref_mem[65] = 32'h1122_3344;
  endtask

  task automatic drive(input bit we, input logic [1:0] size, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input bit track, output int acc);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    while (!req_ready && n < 40) begin @(negedge clk); n++; end
    if (!req_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout addr=%h ready=%b required 1", addr, req_ready);
    end
    @(posedge clk); #1;
    acc = cyc;
    req_valid = 1'b0;
    if (track) begin
      model(we, size, uns, addr, wdata, e.rdata, e.err, e.lat);
      e.acc = acc;
      exp_q.push_back(e);
    end
  endtask

  task automatic collect(output got_t g, output bit ok);
    int n = 0;
    while (got_q.size() == 0 && n < 30) begin @(posedge clk); n++; end
    ok = (got_q.size() != 0);
    if (ok) g = got_q.pop_front();
    else g = '{rdata: 32'hX, err: 1'bX, cyc: -1};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (d_mem_wen !== 4'b0000) begin n_bad++; $display("FAIL reset_wen got %b required 0000", d_mem_wen); end
    rst_n = 1'b1; #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b required 1", req_ready); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b required 0", resp_valid); end
    n_cmp++; if (resp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got %h required 0", resp_rdata); end
    n_cmp++; if (resp_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b required 0", resp_err); end
    n_cmp++; if (d_mem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr got %h required 0", d_mem_addr); end
  endtask

  task automatic test_loads();
    logic [1:0]  sz [6] = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b01, 2'b11};
    bit          us [6] = '{0, 0, 1, 0, 1, 0};
    logic [31:0] ad [6] = '{32'h100, 32'h101, 32'h101, 32'h102, 32'h102, 32'h104};
    logic [31:0] sv [6] = '{32'h8899_AABB, 32'hFFFF_FFAA, 32'h0000_00AA,
                            32'hFFFF_8899, 32'h0000_8899, 32'h1122_3344};
    exp_t e; got_t g; bit ok; int acc;
    preload();
    wen_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, sz[i], us[i], ad[i], 32'h0, 1'b1, acc);
      collect(g, ok);
      e = exp_q.pop_front();
      n_cmp++; if (g.rdata !== sv[i] || g.rdata !== e.rdata) begin n_bad++;
        $display("FAIL load_rdata[%0d] got %h required %h", i, g.rdata, sv[i]); end
      n_cmp++; if (g.err !== 1'b0) begin n_bad++; $display("FAIL load_err[%0d] got %b required 0", i, g.err); end
      n_cmp++; if (g.cyc - acc !== 2) begin n_bad++; $display("FAIL load_latency[%0d] got %0d required 2", i, g.cyc - acc); end
    end
    n_cmp++; if (wen_cycles !== 0) begin n_bad++; $display("FAIL load_wen got %0d cycles required 0", wen_cycles); end
  endtask

  task automatic test_span_load();
    exp_t e; got_t g; bit ok; int acc;
    preload();
    addr_log.delete();
    drive(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 1'b1, acc);
    collect(g, ok);
    e = exp_q.pop_front();
    n_cmp++; if (g.rdata !== 32'h3344_8899) begin n_bad++; $display("FAIL span_rdata got %h required 33448899", g.rdata); end
    n_cmp++; if (g.cyc - acc !== e.lat || e.lat != 3) begin n_bad++; $display("FAIL span_latency got %0d required 3", g.cyc - acc); end
    n_cmp++; if (addr_log.size() != 2 || addr_log[0] !== 32'h100 || addr_log[1] !== 32'h104) begin n_bad++;
      $display("FAIL span_addr_seq got n=%0d first=%h required 100,104", addr_log.size(), addr_log.size() ? addr_log[0] : 32'h0); end
  endtask

  task automatic test_stores();
    exp_t e; got_t g; bit ok; int acc;
    preload(); wen_cycles = 0;
    drive(1'b1, 2'b00, 1'b0, 32'h103, 32'h0000_00EE, 1'b1, acc);
    collect(g, ok); e = exp_q.pop_front();
    n_cmp++; if (mem[64] !== 32'hEE99_AABB) begin n_bad++; $display("FAIL sb_word0 got %h required ee99aabb", mem[64]); end
    n_cmp++; if (mem[65] !== 32'h1122_3344) begin n_bad++; $display("FAIL sb_word1 got %h required 11223344", mem[65]); end
    n_cmp++; if (wen_cycles !== 1) begin n_bad++; $display("FAIL sb_wen_cycles got %0d required 1", wen_cycles); end
    n_cmp++; if (g.cyc - acc !== 3 || g.rdata !== 32'h0 || g.err !== 1'b0) begin n_bad++;
      $display("FAIL sb_resp lat=%0d rdata=%h err=%b required 3/0/0", g.cyc - acc, g.rdata, g.err); end
    preload(); wen_cycles = 0;
    drive(1'b1, 2'b01, 1'b0, 32'h103, 32'h0000_CAFE, 1'b1, acc);
    collect(g, ok); e = exp_q.pop_front();
    n_cmp++; if (mem[64] !== 32'hFE99_AABB) begin n_bad++; $display("FAIL sh_word0 got %h required fe99aabb", mem[64]); end
    n_cmp++; if (mem[65] !== 32'h1122_33CA) begin n_bad++; $display("FAIL sh_word1 got %h required 112233ca", mem[65]); end
    n_cmp++; if (g.cyc - acc !== 5 || wen_cycles !== 2) begin n_bad++;
      $display("FAIL sh_latency got lat=%0d wen=%0d required 5/2", g.cyc - acc, wen_cycles); end
    preload(); wen_cycles = 0;
    drive(1'b1, 2'b10, 1'b0, 32'h104, 32'hCAFE_F00D, 1'b1, acc);
    collect(g, ok); e = exp_q.pop_front();
    n_cmp++; if (mem[65] !== 32'hCAFE_F00D || g.cyc - acc !== 2 || wen_cycles !== 1) begin n_bad++;
      $display("FAIL sw_aligned got mem=%h lat=%0d wen=%0d required cafef00d/2/1", mem[65], g.cyc - acc, wen_cycles); end
  endtask

  task automatic test_oob();
    exp_t e; got_t g; bit ok; int acc;
    preload(); mem[1023] = 32'h5566_7788; ref_mem[1023] = 32'h5566_7788;
    drive(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 1'b1, acc);
    collect(g, ok); e = exp_q.pop_front();
    n_cmp++; if (g.err !== 1'b1 || g.rdata !== 32'h0) begin n_bad++;
      $display("FAIL oob_load got err=%b rdata=%h required 1/0", g.err, g.rdata); end
    wen_cycles = 0;
    drive(1'b1, 2'b01, 1'b0, 32'hFFF, 32'h0000_1234, 1'b1, acc);
    collect(g, ok); e = exp_q.pop_front();
    n_cmp++; if (g.err !== 1'b1 || g.cyc - acc !== 5 || wen_cycles !== 0 || mem[1023] !== 32'h5566_7788) begin n_bad++;
      $display("FAIL oob_span_store got err=%b lat=%0d wen=%0d mem=%h required 1/5/0/55667788",
               g.err, g.cyc - acc, wen_cycles, mem[1023]); end
  endtask

  task automatic test_back_to_back();
    exp_t ea, eb; got_t ga, gb; bit ok; int acc_a, acc_b;
    preload();
    drive(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1, acc_a);
    drive(1'b0, 2'b01, 1'b1, 32'h104, 32'h0, 1'b1, acc_b);
    collect(ga, ok); collect(gb, ok);
    ea = exp_q.pop_front(); eb = exp_q.pop_front();
    n_cmp++; if (acc_b - acc_a !== 3) begin n_bad++; $display("FAIL b2b_accept_gap got %0d required 3", acc_b - acc_a); end
    n_cmp++; if (ga.rdata !== ea.rdata || gb.rdata !== eb.rdata) begin n_bad++;
      $display("FAIL b2b_rdata got %h,%h required %h,%h", ga.rdata, gb.rdata, ea.rdata, eb.rdata); end
  endtask

  task automatic test_random();
    exp_t e; got_t g; bit ok; int acc;
    logic [31:0] a;
    preload();
    for (int i = 56; i < 72; i++) begin mem[i] = $urandom; ref_mem[i] = mem[i]; end
    for (int i = 1016; i < 1024; i++) begin mem[i] = $urandom; ref_mem[i] = mem[i]; end
    for (int i = 0; i < 40; i++) begin
      a = (($urandom_range(0, 4) == 0) ? 32'hFF0 : 32'h0F0) + $urandom_range(0, 23);
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            a, $urandom, 1'b1, acc);
      collect(g, ok); e = exp_q.pop_front();
      n_cmp++; if (!ok || g.rdata !== e.rdata || g.err !== e.err || g.cyc - acc !== e.lat) begin n_bad++;
        $display("FAIL rand[%0d] addr=%h got %h/%b/%0d required %h/%b/%0d",
                 i, a, g.rdata, g.err, g.cyc - acc, e.rdata, e.err, e.lat); end
    end
    for (int i = 56; i < 72; i++) begin
      n_cmp++; if (mem[i] !== ref_mem[i]) begin n_bad++; $display("FAIL rand_mem[%0d] got %h required %h", i, mem[i], ref_mem[i]); end
    end
    for (int i = 1016; i < 1024; i++) begin
      n_cmp++; if (mem[i] !== ref_mem[i]) begin n_bad++; $display("FAIL rand_mem[%0d] got %h required %h", i, mem[i], ref_mem[i]); end
    end
  endtask

  task automatic test_reset_midflight();
    int acc;
    preload();
    drive(1'b1, 2'b01, 1'b0, 32'h103, 32'h0000_CAFE, 1'b0, acc);
    @(posedge clk); @(posedge clk); @(negedge clk);
    n_cmp++; if (d_mem_wen !== 4'b1111) begin n_bad++; $display("FAIL midflight_wr0_wen got %b required 1111", d_mem_wen); end
    rst_n = 1'b0; #1;
    n_cmp++; if (d_mem_wen !== 4'b0000) begin n_bad++; $display("FAIL midflight_wen_forced got %b required 0000", d_mem_wen); end
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst_n = 1'b1; #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL midflight_ready got %b required 1", req_ready); end
    repeat (8) @(posedge clk);
    n_cmp++; if (got_q.size() != 0) begin n_bad++; $display("FAIL midflight_no_resp got %0d responses required 0", got_q.size()); end
    n_cmp++; if (mem[64] !== 32'h8899_AABB || mem[65] !== 32'h1122_3344) begin n_bad++;
      $display("FAIL midflight_mem got %h,%h required 8899aabb,11223344", mem[64], mem[65]); end
  endtask

  initial begin
    preload();
    test_reset();
    test_loads();
    test_span_load();
    test_stores();
    test_oob();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
